// File: rtl/axil_bridge_buf.sv
// axil_bridge_buf : buffered AXI4-Lite slave-to-master bridge.
//
// Every channel passes through its own DEPTH-entry FIFO. Requests go from s0
// to m1 (AW, W, AR) and responses from m1 to s0 (B, R). No more than DEPTH
// writes and DEPTH reads may be outstanding on m1 at once. Because of that
// limit, the B and R FIFOs can never overflow.
//
// Optional feature: define AXIL_BRIDGE_BUF_STATS_EN to add the stat_wr_count
// and stat_rd_count completed-transaction counters.
//
// Ports
//   axi_aclk, axi_areset   clock, async active-high reset
//   s0_axi_aw*/w*/ar*      request channels in from the interconnect
//   s0_axi_b*/r*           response channels out to the interconnect
//   m1_axi_aw*/w*/ar*      request channels out to the peripheral
//   m1_axi_b*/r*           response channels in from the peripheral
//   stat_wr/rd_count       completed B / R handshakes on s0 (STATS_EN only)

// Synchronous FIFO with a register-array body. The pointers carry one extra
// wrap bit, which tells a full FIFO apart from an empty one.
module axil_bridge_buf_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]               wptr_q, rptr_q;
  logic [DEPTH-1:0][W-1:0]   mem_q;
  logic                      do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // A push is allowed while full if a pop happens in the same cycle. The head
  // slot is read before it is overwritten, so occupancy stays the same.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // The body is reset as well, so all payload outputs read 0 during reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= din_i;
        wptr_q                <= wptr_q + PTR_ONE;
      end
      if (do_pop) rptr_q <= rptr_q + PTR_ONE;
    end
  end
endmodule

module axil_bridge_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  // s0: slave side
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [1:0]              s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [1:0]              s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  // m1: master side
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic [1:0]              m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [1:0]              m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
`ifdef AXIL_BRIDGE_BUF_STATS_EN
  ,
  output logic [31:0]             stat_wr_count,
  output logic [31:0]             stat_rd_count
`endif
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] OUT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] OUT_ONE = 1;

  // The readies are gated by a flag that first sets on the clock after reset
  // is released. Without it, the readies would go high while reset is still
  // asserted, because the empty FIFOs report not-full.
  logic rdy_q;
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) rdy_q <= 1'b0;
    else            rdy_q <= 1'b1;
  end

  logic aw_full, aw_empty, w_full, w_empty, ar_full, ar_empty;
  logic b_full, b_empty, r_full, r_empty;
  logic s0_aw_hs, s0_w_hs, s0_ar_hs, s0_b_hs, s0_r_hs;
  logic m1_aw_hs, m1_w_hs, m1_ar_hs, m1_b_hs, m1_r_hs;
  logic [CW-1:0] wr_out_q, wr_out_d, rd_out_q, rd_out_d;

  assign s0_aw_hs = s0_axi_awvalid && s0_axi_awready;
  assign s0_w_hs  = s0_axi_wvalid  && s0_axi_wready;
  assign s0_ar_hs = s0_axi_arvalid && s0_axi_arready;
  assign s0_b_hs  = s0_axi_bvalid  && s0_axi_bready;
  assign s0_r_hs  = s0_axi_rvalid  && s0_axi_rready;
  assign m1_aw_hs = m1_axi_awvalid && m1_axi_awready;
  assign m1_w_hs  = m1_axi_wvalid  && m1_axi_wready;
  assign m1_ar_hs = m1_axi_arvalid && m1_axi_arready;
  assign m1_b_hs  = m1_axi_bvalid  && m1_axi_bready;
  assign m1_r_hs  = m1_axi_rvalid  && m1_axi_rready;

  assign s0_axi_awready = rdy_q && !aw_full;
  assign s0_axi_wready  = rdy_q && !w_full;
  assign s0_axi_arready = rdy_q && !ar_full;
  assign m1_axi_bready  = rdy_q && !b_full;
  assign m1_axi_rready  = rdy_q && !r_full;

  // An address is only issued while a response slot is free downstream. W is
  // not limited this way: a W alone never produces a response.
  assign m1_axi_awvalid = !aw_empty && (wr_out_q < OUT_MAX);
  assign m1_axi_wvalid  = !w_empty;
  assign m1_axi_arvalid = !ar_empty && (rd_out_q < OUT_MAX);
  assign s0_axi_bvalid  = !b_empty;
  assign s0_axi_rvalid  = !r_empty;

  axil_bridge_buf_fifo #(.W(ADDR_WIDTH), .DEPTH(DEPTH)) u_aw_fifo (
    .clk_i(axi_aclk), .rst_i(axi_areset),
    .push_i(s0_aw_hs), .din_i(s0_axi_awaddr),
    .pop_i(m1_aw_hs),  .dout_o(m1_axi_awaddr),
    .full_o(aw_full),  .empty_o(aw_empty));

  axil_bridge_buf_fifo #(.W(DATA_WIDTH + SW), .DEPTH(DEPTH)) u_w_fifo (
    .clk_i(axi_aclk), .rst_i(axi_areset),
    .push_i(s0_w_hs), .din_i({s0_axi_wstrb, s0_axi_wdata}),
    .pop_i(m1_w_hs),  .dout_o({m1_axi_wstrb, m1_axi_wdata}),
    .full_o(w_full),  .empty_o(w_empty));

  axil_bridge_buf_fifo #(.W(ADDR_WIDTH), .DEPTH(DEPTH)) u_ar_fifo (
    .clk_i(axi_aclk), .rst_i(axi_areset),
    .push_i(s0_ar_hs), .din_i(s0_axi_araddr),
    .pop_i(m1_ar_hs),  .dout_o(m1_axi_araddr),
    .full_o(ar_full),  .empty_o(ar_empty));

  axil_bridge_buf_fifo #(.W(2), .DEPTH(DEPTH)) u_b_fifo (
    .clk_i(axi_aclk), .rst_i(axi_areset),
    .push_i(m1_b_hs), .din_i(m1_axi_bresp),
    .pop_i(s0_b_hs),  .dout_o(s0_axi_bresp),
    .full_o(b_full),  .empty_o(b_empty));

  axil_bridge_buf_fifo #(.W(DATA_WIDTH + 2), .DEPTH(DEPTH)) u_r_fifo (
    .clk_i(axi_aclk), .rst_i(axi_areset),
    .push_i(m1_r_hs), .din_i({m1_axi_rresp, m1_axi_rdata}),
    .pop_i(s0_r_hs),  .dout_o({s0_axi_rresp, s0_axi_rdata}),
    .full_o(r_full),  .empty_o(r_empty));

  // Outstanding counts cover the span from the address issue on m1 to the
  // response delivery on s0. This span includes the response FIFO, which is
  // why the response FIFOs are bounded.
  always_comb begin
    wr_out_d = wr_out_q;
    case ({m1_aw_hs, s0_b_hs})
      2'b10:   wr_out_d = wr_out_q + OUT_ONE;
      2'b01:   wr_out_d = wr_out_q - OUT_ONE;
      default: wr_out_d = wr_out_q;
    endcase
  end

  always_comb begin
    rd_out_d = rd_out_q;
    case ({m1_ar_hs, s0_r_hs})
      2'b10:   rd_out_d = rd_out_q + OUT_ONE;
      2'b01:   rd_out_d = rd_out_q - OUT_ONE;
      default: rd_out_d = rd_out_q;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_out_q <= '0;
      rd_out_q <= '0;
    end else begin
      wr_out_q <= wr_out_d;
      rd_out_q <= rd_out_d;
    end
  end

`ifdef AXIL_BRIDGE_BUF_STATS_EN
  logic [31:0] stat_wr_q, stat_rd_q;
  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      if (s0_b_hs) stat_wr_q <= stat_wr_q + 32'd1;
      if (s0_r_hs) stat_rd_q <= stat_rd_q + 32'd1;
    end
  end
  assign stat_wr_count = stat_wr_q;
  assign stat_rd_count = stat_rd_q;
`endif
endmodule

// File: tb/tb_axil_bridge_buf.sv
module tb_axil_bridge_buf;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0]  s0_awaddr, s0_araddr, m1_awaddr, m1_araddr;
  logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [31:0] s0_wdata, s0_rdata, m1_wdata, m1_rdata;
  logic [3:0]  s0_wstrb, m1_wstrb;
  logic [1:0]  s0_bresp, s0_rresp, m1_bresp, m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
`ifdef AXIL_BRIDGE_BUF_STATS_EN
  logic [31:0] stat_wr_count, stat_rd_count;
`endif

  axil_bridge_buf #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(4)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .s0_axi_awaddr(s0_awaddr), .s0_axi_awvalid(s0_awvalid), .s0_axi_awready(s0_awready),
    .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb), .s0_axi_wvalid(s0_wvalid), .s0_axi_wready(s0_wready),
    .s0_axi_bresp(s0_bresp), .s0_axi_bvalid(s0_bvalid), .s0_axi_bready(s0_bready),
    .s0_axi_araddr(s0_araddr), .s0_axi_arvalid(s0_arvalid), .s0_axi_arready(s0_arready),
    .s0_axi_rdata(s0_rdata), .s0_axi_rresp(s0_rresp), .s0_axi_rvalid(s0_rvalid), .s0_axi_rready(s0_rready),
    .m1_axi_awaddr(m1_awaddr), .m1_axi_awvalid(m1_awvalid), .m1_axi_awready(m1_awready),
    .m1_axi_wdata(m1_wdata), .m1_axi_wstrb(m1_wstrb), .m1_axi_wvalid(m1_wvalid), .m1_axi_wready(m1_wready),
    .m1_axi_bresp(m1_bresp), .m1_axi_bvalid(m1_bvalid), .m1_axi_bready(m1_bready),
    .m1_axi_araddr(m1_araddr), .m1_axi_arvalid(m1_arvalid), .m1_axi_arready(m1_arready),
    .m1_axi_rdata(m1_rdata), .m1_axi_rresp(m1_rresp), .m1_axi_rvalid(m1_rvalid), .m1_axi_rready(m1_rready)
`ifdef AXIL_BRIDGE_BUF_STATS_EN
    , .stat_wr_count(stat_wr_count), .stat_rd_count(stat_rd_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_bhs = 0;
  int n_rhs = 0;
  int n_m1ar = 0;

  // scoreboard queues, pushed at s0 acceptance
  logic [7:0]  exp_aw[$];
  logic [35:0] exp_w[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  // peripheral configuration
  logic [1:0]  cfg_bresp = 2'b00;
  logic [1:0]  cfg_rresp = 2'b00;
  logic        cfg_fix   = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  logic        r_en      = 1'b1;

  function automatic logic [31:0] rd_val(input logic [7:0] a);
    return 32'hC0DE0000 | {24'h0, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Peripheral model on m1 plus the scoreboard monitor. Handshakes are sampled
  // at the negedge, which means they complete on the following posedge.
  logic [7:0]  paw[$];
  logic [35:0] pw[$];
  logic [1:0]  pb[$];
  logic [33:0] pr[$];
  logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [7:0] ar_a;
  logic [7:0] aw_a;
  logic [35:0] w_d;

  initial begin
    m1_bvalid = 1'b0; m1_bresp = 2'b00;
    m1_rvalid = 1'b0; m1_rdata = 32'h0; m1_rresp = 2'b00;
    forever begin
      @(negedge clk);
      hs_aw = m1_awvalid && m1_awready; aw_a = m1_awaddr;
      hs_w  = m1_wvalid && m1_wready;   w_d  = {m1_wstrb, m1_wdata};
      hs_ar = m1_arvalid && m1_arready; ar_a = m1_araddr;
      hs_b  = m1_bvalid && m1_bready;
      hs_r  = m1_rvalid && m1_rready;
      if (!rst) begin
        if (hs_aw) begin
          n_cmp++;
          if (exp_aw.size() == 0) begin n_err++; $display("FAIL m1_aw unexpected addr=%h", aw_a); end
          else if (aw_a !== exp_aw[0]) begin n_err++; $display("FAIL m1_aw got=%h exp=%h", aw_a, exp_aw[0]); void'(exp_aw.pop_front()); end
          else void'(exp_aw.pop_front());
        end
        if (hs_w) begin
          n_cmp++;
          if (exp_w.size() == 0) begin n_err++; $display("FAIL m1_w unexpected data=%h", w_d); end
          else if (w_d !== exp_w[0]) begin n_err++; $display("FAIL m1_w got=%h exp=%h", w_d, exp_w[0]); void'(exp_w.pop_front()); end
          else void'(exp_w.pop_front());
        end
        if (hs_ar) n_m1ar++;
        if (s0_bvalid && s0_bready) begin
          n_bhs++; n_cmp++;
          if (exp_b.size() == 0) begin n_err++; $display("FAIL s0_b unexpected bresp=%h", s0_bresp); end
          else if (s0_bresp !== exp_b[0]) begin n_err++; $display("FAIL s0_b got=%h exp=%h", s0_bresp, exp_b[0]); void'(exp_b.pop_front()); end
          else void'(exp_b.pop_front());
        end
        if (s0_rvalid && s0_rready) begin
          n_rhs++; n_cmp++;
          if (exp_r.size() == 0) begin n_err++; $display("FAIL s0_r unexpected resp/data=%h", {s0_rresp, s0_rdata}); end
          else if ({s0_rresp, s0_rdata} !== exp_r[0]) begin
            n_err++; $display("FAIL s0_r got=%h exp=%h", {s0_rresp, s0_rdata}, exp_r[0]); void'(exp_r.pop_front());
          end else void'(exp_r.pop_front());
        end
      end
      @(posedge clk);
      #1;
      if (rst) begin
        paw.delete(); pw.delete(); pb.delete(); pr.delete();
      end else begin
        if (hs_b) void'(pb.pop_front());
        if (hs_r) void'(pr.pop_front());
        if (hs_aw) paw.push_back(aw_a);
        if (hs_w) pw.push_back(w_d);
        if (hs_ar) pr.push_back({cfg_rresp, cfg_fix ? cfg_rdata : rd_val(ar_a)});
        while (paw.size() != 0 && pw.size() != 0) begin
          void'(paw.pop_front()); void'(pw.pop_front());
          pb.push_back(cfg_bresp);
        end
      end
      m1_bvalid = (pb.size() != 0);
      m1_bresp  = (pb.size() != 0) ? pb[0] : 2'b00;
      m1_rvalid = r_en && (pr.size() != 0);
      m1_rdata  = (pr.size() != 0) ? pr[0][31:0] : 32'h0;
      m1_rresp  = (pr.size() != 0) ? pr[0][33:32] : 2'b00;
    end
  end

  // s0 master tasks
  task automatic send_aw(input logic [7:0] a);
    bit ok = 0;
    s0_awaddr = a; s0_awvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s0_awready) begin ok = 1; break; end
    end
    if (ok) exp_aw.push_back(a);
    else begin n_cmp++; n_err++; $display("FAIL aw_accept timeout addr=%h got=0 exp=1", a); end
    step();
    s0_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    s0_wdata = d; s0_wstrb = s; s0_wvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s0_wready) begin ok = 1; break; end
    end
    if (ok) exp_w.push_back({s, d});
    else begin n_cmp++; n_err++; $display("FAIL w_accept timeout got=0 exp=1"); end
    step();
    s0_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] a);
    bit ok = 0;
    s0_araddr = a; s0_arvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s0_arready) begin ok = 1; break; end
    end
    if (ok) exp_r.push_back({cfg_rresp, cfg_fix ? cfg_rdata : rd_val(a)});
    else begin n_cmp++; n_err++; $display("FAIL ar_accept timeout addr=%h got=0 exp=1", a); end
    step();
    s0_arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_aw.size() == 0 && exp_w.size() == 0 && exp_b.size() == 0 && exp_r.size() == 0) begin
        ok = 1; break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL drain timeout pending aw=%0d w=%0d b=%0d r=%0d exp=0", exp_aw.size(), exp_w.size(), exp_b.size(), exp_r.size());
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s0_awaddr = 0; s0_awvalid = 0; s0_wdata = 0; s0_wstrb = 0; s0_wvalid = 0;
    s0_araddr = 0; s0_arvalid = 0; s0_bready = 1; s0_rready = 1;
    m1_awready = 1; m1_wready = 1; m1_arready = 1;
    repeat (3) step();
    n_cmp++;
    if ({s0_awready, s0_wready, s0_arready, m1_bready, m1_rready} !== 5'b0) begin
      n_err++; $display("FAIL reset_readies got=%b exp=00000", {s0_awready, s0_wready, s0_arready, m1_bready, m1_rready});
    end
    n_cmp++;
    if ({s0_bvalid, s0_rvalid, m1_awvalid, m1_wvalid, m1_arvalid} !== 5'b0) begin
      n_err++; $display("FAIL reset_valids got=%b exp=00000", {s0_bvalid, s0_rvalid, m1_awvalid, m1_wvalid, m1_arvalid});
    end
    n_cmp++;
    if ({m1_awaddr, m1_araddr, m1_wdata, m1_wstrb, s0_rdata, s0_rresp, s0_bresp} !== 88'h0) begin
      n_err++; $display("FAIL reset_payload got=%h exp=0", {m1_awaddr, m1_araddr, m1_wdata, m1_wstrb, s0_rdata, s0_rresp, s0_bresp});
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({s0_awready, s0_wready, s0_arready, m1_bready, m1_rready} !== 5'b11111) begin
      n_err++; $display("FAIL post_reset_readies got=%b exp=11111", {s0_awready, s0_wready, s0_arready, m1_bready, m1_rready});
    end
    step();
  endtask

  task automatic test_single_write();
    bit ok = 0;
    cfg_bresp = 2'b00;
    send_aw(8'h10);
    @(negedge clk);
    n_cmp++;
    if (m1_awvalid !== 1'b1 || m1_awaddr !== 8'h10) begin
      n_err++; $display("FAIL sw_aw_latency got=%b/%h exp=1/10", m1_awvalid, m1_awaddr);
    end
    step();
    send_w(32'hDEADBEEF, 4'hF);
    @(negedge clk);
    n_cmp++;
    if (m1_wvalid !== 1'b1 || {m1_wstrb, m1_wdata} !== 36'hFDEADBEEF) begin
      n_err++; $display("FAIL sw_w_latency got=%b/%h exp=1/fdeadbeef", m1_wvalid, {m1_wstrb, m1_wdata});
    end
    exp_b.push_back(2'b00);
    for (int i = 0; i < 50; i++) begin
      if (m1_bvalid && m1_bready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (!ok || s0_bvalid !== 1'b1 || s0_bresp !== 2'b00) begin
      n_err++; $display("FAIL sw_b_latency got=%b/%b exp=1/00", s0_bvalid, s0_bresp);
    end
    step();
    wait_drain();
  endtask

  task automatic test_w_before_aw();
    int base = n_bhs;
    send_w(32'hA5A50001, 4'b0011);
    repeat (3) step();
    send_aw(8'h20);
    exp_b.push_back(cfg_bresp);
    wait_drain();
    repeat (3) step();
    n_cmp++;
    if (n_bhs - base !== 1) begin n_err++; $display("FAIL wba_b_count got=%0d exp=1", n_bhs - base); end
    n_cmp++;
    if (dut.wr_out_q !== 3'd0) begin n_err++; $display("FAIL wba_wr_out got=%0d exp=0", dut.wr_out_q); end
  endtask

  task automatic test_outstanding_limit();
    int base = n_m1ar;
    r_en = 1'b0;
    for (int i = 0; i < 6; i++) send_ar(8'(i * 4));
    repeat (5) step();
    @(negedge clk);
    n_cmp++;
    if (n_m1ar - base !== 4) begin n_err++; $display("FAIL ol_ar_count got=%0d exp=4", n_m1ar - base); end
    n_cmp++;
    if (m1_arvalid !== 1'b0) begin n_err++; $display("FAIL ol_arvalid got=%b exp=0", m1_arvalid); end
    n_cmp++;
    if (3'(dut.u_ar_fifo.wptr_q - dut.u_ar_fifo.rptr_q) !== 3'd2) begin
      n_err++; $display("FAIL ol_ar_fill got=%0d exp=2", 3'(dut.u_ar_fifo.wptr_q - dut.u_ar_fifo.rptr_q));
    end
    step();
    r_en = 1'b1;
    wait_drain();
    n_cmp++;
    if (n_m1ar - base !== 6 || dut.rd_out_q !== 3'd0) begin
      n_err++; $display("FAIL ol_drain got=%0d/%0d exp=6/0", n_m1ar - base, dut.rd_out_q);
    end
  endtask

  task automatic test_backpressure();
    cfg_bresp = 2'b01;
    s0_bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_aw(8'(8'h40 + i * 4)); send_w(32'h1000 + i, 4'hF); exp_b.push_back(2'b01);
    end
    repeat (8) step();
    @(negedge clk);
    n_cmp++;
    if (m1_bready !== 1'b0 || s0_bvalid !== 1'b1) begin
      n_err++; $display("FAIL bp_b_full got=%b/%b exp=0/1", m1_bready, s0_bvalid);
    end
    step();
    for (int i = 4; i < 6; i++) begin
      send_aw(8'(8'h40 + i * 4)); send_w(32'h1000 + i, 4'hF); exp_b.push_back(2'b01);
    end
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if (s0_awready !== 1'b1 || m1_awvalid !== 1'b0) begin
      n_err++; $display("FAIL bp_aw_2 got=%b/%b exp=1/0", s0_awready, m1_awvalid);
    end
    step();
    for (int i = 6; i < 8; i++) begin
      send_aw(8'(8'h40 + i * 4)); send_w(32'h1000 + i, 4'hF); exp_b.push_back(2'b01);
    end
    repeat (2) step();
    @(negedge clk);
    n_cmp++;
    if (s0_awready !== 1'b0) begin n_err++; $display("FAIL bp_aw_full got=%b exp=0", s0_awready); end
    step();
    s0_bready = 1'b1;
    wait_drain();
    n_cmp++;
    if (dut.wr_out_q !== 3'd0) begin n_err++; $display("FAIL bp_wr_out got=%0d exp=0", dut.wr_out_q); end
    cfg_bresp = 2'b00;
  endtask

  task automatic test_resp_passthrough();
    cfg_rresp = 2'b10; cfg_fix = 1'b1; cfg_rdata = 32'h12345678;
    send_ar(8'h30);
    wait_drain();
    cfg_rresp = 2'b00; cfg_fix = 1'b0;
    cfg_bresp = 2'b11;
    send_aw(8'h34); send_w(32'h0BAD0BAD, 4'b1001); exp_b.push_back(2'b11);
    wait_drain();
    cfg_bresp = 2'b00;
  endtask

  task automatic test_back_to_back();
    int base = n_rhs;
    for (int i = 0; i < 4; i++) send_ar(8'(8'h80 + i));
    wait_drain();
    n_cmp++;
    if (n_rhs - base !== 4) begin n_err++; $display("FAIL b2b_r_count got=%0d exp=4", n_rhs - base); end
  endtask

  task automatic test_reset_mid();
    bit stale = 0;
    r_en = 1'b0;
    for (int i = 0; i < 3; i++) send_ar(8'(8'h60 + i * 4));
    repeat (4) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({s0_bvalid, s0_rvalid, m1_awvalid, m1_wvalid, m1_arvalid, s0_arready} !== 6'b0) begin
      n_err++; $display("FAIL rm_valids got=%b exp=000000", {s0_bvalid, s0_rvalid, m1_awvalid, m1_wvalid, m1_arvalid, s0_arready});
    end
    exp_r.delete();
    repeat (3) step();
    rst = 1'b0;
    r_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s0_rvalid) stale = 1;
    end
    n_cmp++;
    if (stale) begin n_err++; $display("FAIL rm_stale_r got=1 exp=0"); end
`ifdef AXIL_BRIDGE_BUF_STATS_EN
    n_cmp++;
    if (stat_wr_count !== 32'd0 || stat_rd_count !== 32'd0) begin
      n_err++; $display("FAIL rm_stats got=%0d/%0d exp=0/0", stat_wr_count, stat_rd_count);
    end
`endif
    step();
  endtask

  task automatic test_stats();
    send_aw(8'h50); send_w(32'h55, 4'h1); exp_b.push_back(2'b00);
    send_ar(8'h54);
    wait_drain();
`ifdef AXIL_BRIDGE_BUF_STATS_EN
    n_cmp++;
    if (stat_wr_count !== 32'd1 || stat_rd_count !== 32'd1) begin
      n_err++; $display("FAIL stats got=%0d/%0d exp=1/1", stat_wr_count, stat_rd_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_w_before_aw();
    test_outstanding_limit();
    test_backpressure();
    test_resp_passthrough();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
